// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID and MEM. Holds the ID bundle, runs the ALU,
// issues data-SRAM requests with byte-lane store formatting, feeds the external
// multiplier and runs a 32-step restoring divider that stalls the stage.

// alu: one-hot opcode ALU. Bit map of alu_op:
//   0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor,
//   8 sll, 9 srl, 10 sra, 11 lui (passes src2), 12 andn, 13 orn, 14-18 reserved (0)
module alu (
   input  logic [18:0] alu_op,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);
   logic        use_sub;
   logic [31:0] adder_b;
   logic [32:0] adder_sum;
   logic        slt_res;
   logic        sltu_res;
   logic [31:0] sra_res;

   // sub, slt and sltu all share the adder in subtract mode
   assign use_sub   = alu_op[1] | alu_op[2] | alu_op[3];
   assign adder_b   = use_sub ? ~alu_src2 : alu_src2;
   assign adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};
   assign slt_res   = (alu_src1[31] & ~alu_src2[31]) |
                      (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
   assign sltu_res  = ~adder_sum[32];
   assign sra_res   = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);

   // one-hot select: each enabled op ORs its result in
   always_comb begin
      alu_result = 32'd0;
      if (alu_op[0] | alu_op[1]) alu_result = alu_result | adder_sum[31:0];
      if (alu_op[2])  alu_result = alu_result | {31'd0, slt_res};
      if (alu_op[3])  alu_result = alu_result | {31'd0, sltu_res};
      if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
      if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
      if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
      if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
      if (alu_op[8])  alu_result = alu_result | (alu_src1 << alu_src2[4:0]);
      if (alu_op[9])  alu_result = alu_result | (alu_src1 >> alu_src2[4:0]);
      if (alu_op[10]) alu_result = alu_result | sra_res;
      if (alu_op[11]) alu_result = alu_result | alu_src2;
      if (alu_op[12]) alu_result = alu_result | (alu_src1 & ~alu_src2);
      if (alu_op[13]) alu_result = alu_result | (alu_src1 | ~alu_src2);
   end
endmodule

module ex_stage (
   input  logic         clk,
   input  logic         resetn,
   output logic         ex_allowin,
   input  logic         id_to_ex_valid,
   input  logic [167:0] id_to_ex_wire,
   input  logic         mem_allowin,
   output logic         ex_to_mem_valid,
   output logic [109:0] ex_to_mem_wire,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_we,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata,
   output logic [31:0]  mul_src1,
   output logic [31:0]  mul_src2,
   output logic         mul_signed,
   output logic [38:0]  ex_rf_zip
);
   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

   logic         ex_valid_q;
   logic [167:0] bundle_q;
   div_state_e   div_state_q;
   logic [63:0]  div_pair_q;    // {partial remainder, dividend/quotient}
   logic [31:0]  divisor_q;
   logic [5:0]   div_cnt_q;

   // bundle fields
   logic [18:0] alu_op;
   logic [31:0] alu_src1, alu_src2, pc, rkd_value, alu_result;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
   logic        st_b, st_h, st_w;
   logic        mul_l, mul_h, mul_hu;
   logic        div_w, mod_w, div_wu, mod_wu;

   assign {alu_op, alu_src1, alu_src2, rf_we, rf_waddr, pc,
           ld_b, ld_bu, ld_h, ld_hu, ld_w, st_b, st_h, st_w, rkd_value,
           mul_l, mul_h, mul_hu, div_w, mod_w, div_wu, mod_wu} = bundle_q;

   logic is_load, is_store, is_mul, is_div, div_signed;
   logic ex_ready_go, mem_req;

   assign is_load    = ld_b | ld_bu | ld_h | ld_hu | ld_w;
   assign is_store   = st_b | st_h | st_w;
   assign is_mul     = mul_l | mul_h | mul_hu;
   assign is_div     = div_w | mod_w | div_wu | mod_wu;
   assign div_signed = div_w | mod_w;

   assign ex_ready_go     = is_div ? (div_state_q == DIV_DONE) : 1'b1;
   assign ex_allowin      = ~ex_valid_q | (ex_ready_go & mem_allowin);
   assign ex_to_mem_valid = ex_valid_q & ex_ready_go;

   alu u_alu (
      .alu_op     (alu_op),
      .alu_src1   (alu_src1),
      .alu_src2   (alu_src2),
      .alu_result (alu_result)
   );

   // pipeline valid bit
   always_ff @(posedge clk) begin
      if (!resetn)         ex_valid_q <= 1'b0;
      else if (ex_allowin) ex_valid_q <= id_to_ex_valid;
   end

   // bundle register; contents are don't-care while ex_valid_q is low
   always_ff @(posedge clk) begin
      if (id_to_ex_valid & ex_allowin) bundle_q <= id_to_ex_wire;
   end

   // ---------------- divider ----------------
   logic [31:0] dividend_abs, divisor_abs;
   logic [32:0] div_partial;
   logic [33:0] div_diff;
   logic        div_ge;
   logic [63:0] div_pair_d;

   assign dividend_abs = (div_signed & alu_src1[31]) ? (~alu_src1 + 32'd1) : alu_src1;
   assign divisor_abs  = (div_signed & alu_src2[31]) ? (~alu_src2 + 32'd1) : alu_src2;

   // one restoring step: shift left, subtract the divisor if it fits.
   // The remainder can reach 33 bits after the shift, hence the wider compare.
   assign div_partial = div_pair_q[63:31];
   assign div_diff    = {1'b0, div_partial} - {2'b00, divisor_q};
   assign div_ge      = ~div_diff[33];
   assign div_pair_d  = div_ge ? {div_diff[31:0], div_pair_q[30:0], 1'b1}
                               : {div_pair_q[62:0], 1'b0};

   // divider control: latch magnitudes, iterate 32 times, wait for MEM
   always_ff @(posedge clk) begin
      if (!resetn) begin
         div_state_q <= DIV_IDLE;
         div_cnt_q   <= 6'd0;
         div_pair_q  <= 64'd0;
         divisor_q   <= 32'd0;
      end else begin
         case (div_state_q)
            DIV_IDLE: begin
               if (ex_valid_q & is_div) begin
                  div_state_q <= DIV_BUSY;
                  div_pair_q  <= {32'd0, dividend_abs};
                  divisor_q   <= divisor_abs;
                  div_cnt_q   <= 6'd0;
               end
            end
            DIV_BUSY: begin
               div_pair_q <= div_pair_d;
               div_cnt_q  <= div_cnt_q + 6'd1;
               if (div_cnt_q == 6'd31) div_state_q <= DIV_DONE;
            end
            DIV_DONE: begin
               if (ex_to_mem_valid & mem_allowin) div_state_q <= DIV_IDLE;
            end
            default: div_state_q <= DIV_IDLE;
         endcase
      end
   end

   logic [31:0] quot_mag, rem_mag, quot_fix, rem_fix, div_result;

   // sign fix: quotient negative when signs differ, remainder follows the dividend
   assign quot_mag   = div_pair_q[31:0];
   assign rem_mag    = div_pair_q[63:32];
   assign quot_fix   = (div_signed & (alu_src1[31] ^ alu_src2[31])) ? (~quot_mag + 32'd1) : quot_mag;
   assign rem_fix    = (div_signed & alu_src1[31]) ? (~rem_mag + 32'd1) : rem_mag;
   assign div_result = !is_div ? 32'd0 : ((div_w | div_wu) ? quot_fix : rem_fix);

   // ---------------- data SRAM ----------------
   logic [3:0] store_we;

   // only request when MEM will take the instruction next edge: one access each
   assign mem_req = ex_valid_q & (is_load | is_store) & mem_allowin;

   // byte-lane enables and replicated write data for each store size
   always_comb begin
      store_we        = 4'b0000;
      data_sram_wdata = rkd_value;
      if (st_b) begin
         store_we        = 4'b0001 << alu_result[1:0];
         data_sram_wdata = {4{rkd_value[7:0]}};
      end else if (st_h) begin
         store_we        = 4'b0011 << {alu_result[1], 1'b0};
         data_sram_wdata = {2{rkd_value[15:0]}};
      end else if (st_w) begin
         store_we        = 4'b1111;
      end
   end

   assign data_sram_en   = mem_req;
   assign data_sram_we   = (mem_req & is_store) ? store_we : 4'b0000;
   assign data_sram_addr = alu_result;

   // ---------------- multiplier / outputs ----------------
   assign mul_src1   = alu_src1;
   assign mul_src2   = alu_src2;
   assign mul_signed = mul_l | mul_h;

   assign ex_to_mem_wire = {rf_we, rf_waddr, pc, alu_result,
                            ld_b, ld_bu, ld_h, ld_hu, ld_w,
                            is_mul, mul_h | mul_hu, is_div,
                            div_result};

   assign ex_rf_zip = {ex_valid_q & (is_load | is_mul | is_div),
                       ex_valid_q & rf_we,
                       rf_waddr,
                       alu_result};
endmodule
